// File: rtl/npc_mc_core_pkg.sv
// Shared types and constants for the multi-cycle RV32 core: FSM states,
// opcode encodings, decode bundle and immediate extractors.
package npc_mc_core_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        EXEC       = 2'd2,
        STOP       = 2'd3
    } state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic known;
        logic uses_rs1;
        logic wen;
        logic is_ebreak;
    } dec_t;

    function automatic logic [31:0] imm_i(input logic [11:0] f);
        return {{20{f[11]}}, f};
    endfunction

    function automatic logic [31:0] imm_u(input logic [19:0] f);
        return {f, 12'b0};
    endfunction

    // f is ir[31:12]; reassemble the scrambled J-type offset
    function automatic logic [31:0] imm_j(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/npc_mc_core_if.sv
// Valid/ready instruction fetch bus: request carries the PC, response the word.
interface npc_mc_core_if #(
    parameter int DATA_LEN = 32
) ();
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/npc_regfile.sv
// Architectural register file: one async read, one sync write, x0 hardwired
// to zero, synchronous clear. Indices at or above REG_NUM read as zero.
module npc_regfile #(
    parameter int DATA_LEN = 32,
    parameter int REG_NUM  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [4:0]          raddr,
    output logic [DATA_LEN-1:0] rdata
);
    localparam int         AW   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [5:0] NREG = 6'(REG_NUM);

    logic [DATA_LEN-1:0] regs_q [REG_NUM];
    logic                w_hit;
    logic                r_hit;

    assign w_hit = we && (waddr != 5'd0) && ({1'b0, waddr} < NREG);
    assign r_hit = (raddr != 5'd0) && ({1'b0, raddr} < NREG);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (w_hit) begin
            regs_q[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_hit ? regs_q[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/npc_mc_core.sv
// Multi-cycle RV32 core (ADDI/LUI/AUIPC/JAL/JALR/EBREAK) fetching over a
// valid/ready bus, with a single-cycle retire pulse for difftest.
module npc_mc_core
    import npc_mc_core_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter int                  REG_NUM  = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    npc_mc_core_if.master       imem,
    output logic [DATA_LEN-1:0] PC_out,
    output logic                retire_valid,
    output logic [DATA_LEN-1:0] retire_pc,
    output logic [4:0]          retire_rd,
    output logic [DATA_LEN-1:0] retire_wdata,
    output logic                halt,
    output logic                illegal
);
    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic                halt_q, halt_d;
    logic                illegal_q, illegal_d;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [4:0]          rd, rs1;
    logic [DATA_LEN-1:0] rs1_val, pc_plus4, alu_res, npc;
    dec_t                dec;
    logic                regs_ok, legal, rf_we;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign pc_plus4 = pc_q + DATA_LEN'(4);

    npc_regfile #(
        .DATA_LEN (DATA_LEN),
        .REG_NUM  (REG_NUM)
    ) u_regfile (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .we    (rf_we),
        .waddr (rd),
        .wdata (alu_res),
        .raddr (rs1),
        .rdata (rs1_val)
    );

    always_comb begin
        dec     = '0;
        alu_res = '0;
        npc     = pc_plus4;
        case (opcode)
            OP_IMM: if (funct3 == F3_ADDI) begin
                dec     = '{known: 1'b1, uses_rs1: 1'b1, wen: 1'b1, is_ebreak: 1'b0};
                alu_res = rs1_val + DATA_LEN'(imm_i(ir_q[31:20]));
            end
            OP_LUI: begin
                dec     = '{known: 1'b1, uses_rs1: 1'b0, wen: 1'b1, is_ebreak: 1'b0};
                alu_res = DATA_LEN'(imm_u(ir_q[31:12]));
            end
            OP_AUIPC: begin
                dec     = '{known: 1'b1, uses_rs1: 1'b0, wen: 1'b1, is_ebreak: 1'b0};
                alu_res = pc_q + DATA_LEN'(imm_u(ir_q[31:12]));
            end
            OP_JAL: begin
                dec     = '{known: 1'b1, uses_rs1: 1'b0, wen: 1'b1, is_ebreak: 1'b0};
                alu_res = pc_plus4;
                npc     = pc_q + DATA_LEN'(imm_j(ir_q[31:12]));
            end
            OP_JALR: if (funct3 == F3_JALR) begin
                // rs1_val comes from the async read port, so rd == rs1 still sees the old value
                dec     = '{known: 1'b1, uses_rs1: 1'b1, wen: 1'b1, is_ebreak: 1'b0};
                alu_res = pc_plus4;
                npc     = (rs1_val + DATA_LEN'(imm_i(ir_q[31:20]))) & ~DATA_LEN'(1);
            end
            OP_SYSTEM: if (ir_q == INST_EBREAK) begin
                dec = '{known: 1'b1, uses_rs1: 1'b0, wen: 1'b0, is_ebreak: 1'b1};
            end
            default: ;
        endcase
        // Only the fields an instruction actually uses are range-checked on RV32E
        regs_ok = (REG_NUM > 16) || (!(dec.wen && rd[4]) && !(dec.uses_rs1 && rs1[4]));
        legal   = dec.known && regs_ok;
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        halt_d         = halt_q;
        illegal_d      = illegal_q;
        imem.req_valid = 1'b0;
        imem.req_addr  = pc_q;
        imem.rsp_ready = 1'b0;
        rf_we          = 1'b0;
        retire_valid   = 1'b0;
        retire_pc      = '0;
        retire_rd      = '0;
        retire_wdata   = '0;
        if (!sys_rst) begin
            case (state_q)
                FETCH_REQ: begin
                    imem.req_valid = 1'b1;
                    if (imem.req_ready) state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    imem.rsp_ready = 1'b1;
                    if (imem.rsp_valid) begin
                        ir_d    = imem.rsp_data;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    if (legal) begin
                        rf_we        = dec.wen && (rd != 5'd0);
                        pc_d         = npc;
                        retire_valid = 1'b1;
                        retire_pc    = pc_q;
                        retire_rd    = rf_we ? rd : 5'd0;
                        retire_wdata = rf_we ? alu_res : '0;
                        halt_d       = halt_q | dec.is_ebreak;
                        state_d      = dec.is_ebreak ? STOP : FETCH_REQ;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = STOP;
                    end
                end
                STOP: ;
                default: state_d = FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
        end
    end

    assign PC_out  = pc_q;
    assign halt    = halt_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_npc_mc_core.sv
// Directed bench for npc_mc_core: an RV32I instance and an RV32E instance,
// each fed by a small instruction memory model with a controllable req_ready.
module tb_npc_mc_core;
    localparam logic [31:0] RST_A = 32'h8000_0000;
    localparam logic [31:0] RST_B = 32'h0000_2000;

    localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
    localparam logic [31:0] LUI_X2      = 32'hFFFF_F137;
    localparam logic [31:0] ADDI_X2_M1  = 32'hFFF1_0113;
    localparam logic [31:0] ADDI_X0_7   = 32'h0070_0013;
    localparam logic [31:0] ADDI_X3_101 = 32'h1010_0193;
    localparam logic [31:0] JALR_X3     = 32'h0001_81E7;
    localparam logic [31:0] AUIPC_X5_1  = 32'h0000_1297;
    localparam logic [31:0] JAL_X6_8    = 32'h0080_036F;
    localparam logic [31:0] ADDI_X7_1   = 32'h0010_0393;
    localparam logic [31:0] ADDI_X17_1  = 32'h0010_0893;
    localparam logic [31:0] ADDI_X4_X3  = 32'h0001_8213;
    localparam logic [31:0] EBREAK      = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic mem_rdy = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] mem [logic [31:0]];

    npc_mc_core_if #(.DATA_LEN(32)) ia ();
    npc_mc_core_if #(.DATA_LEN(32)) ib ();

    logic [31:0] a_pc, a_rpc, a_rwd, b_pc, b_rpc, b_rwd;
    logic [4:0]  a_rrd, b_rrd;
    logic        a_rv, a_halt, a_ill, b_rv, b_halt, b_ill;

    npc_mc_core #(.DATA_LEN(32), .REG_NUM(32), .RESET_PC(RST_A)) dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .imem(ia), .PC_out(a_pc),
        .retire_valid(a_rv), .retire_pc(a_rpc), .retire_rd(a_rrd), .retire_wdata(a_rwd),
        .halt(a_halt), .illegal(a_ill)
    );

    npc_mc_core #(.DATA_LEN(32), .REG_NUM(16), .RESET_PC(RST_B)) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .imem(ib), .PC_out(b_pc),
        .retire_valid(b_rv), .retire_pc(b_rpc), .retire_rd(b_rrd), .retire_wdata(b_rwd),
        .halt(b_halt), .illegal(b_ill)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return EBREAK;
    endfunction

    // Memory models: response appears the cycle after request acceptance
    assign ia.req_ready = mem_rdy;
    assign ib.req_ready = 1'b1;

    always @(posedge clk) begin
        if (rst_a) begin
            ia.rsp_valid <= 1'b0;
            ia.rsp_data  <= '0;
        end else begin
            if (ia.rsp_valid && ia.rsp_ready) ia.rsp_valid <= 1'b0;
            if (ia.req_valid && ia.req_ready) begin
                ia.rsp_valid <= 1'b1;
                ia.rsp_data  <= mem_rd(ia.req_addr);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_b) begin
            ib.rsp_valid <= 1'b0;
            ib.rsp_data  <= '0;
        end else begin
            if (ib.rsp_valid && ib.rsp_ready) ib.rsp_valid <= 1'b0;
            if (ib.req_valid && ib.req_ready) begin
                ib.rsp_valid <= 1'b1;
                ib.rsp_data  <= mem_rd(ib.req_addr);
            end
        end
    end

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic wait_retire(input int maxc, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            seen = a_rv;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        n_vec += 6;
        if (ia.req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %0b want 0", ia.req_valid); end
        if (ia.rsp_ready !== 1'b0) begin n_err++; $display("FAIL rst_rsp_ready got %0b want 0", ia.rsp_ready); end
        if (a_pc !== RST_A) begin n_err++; $display("FAIL rst_pc got %h want %h", a_pc, RST_A); end
        if ({a_rv, a_rpc, a_rrd, a_rwd} !== '0) begin n_err++; $display("FAIL rst_retire got %0b/%h/%0d/%h want zeros", a_rv, a_rpc, a_rrd, a_rwd); end
        if (a_halt !== 1'b0) begin n_err++; $display("FAIL rst_halt got %0b want 0", a_halt); end
        if (a_ill !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %0b want 0", a_ill); end
    endtask

    task automatic test_basic();
        bit seen; int cyc;
        mem.delete();
        mem[RST_A] = ADDI_X1_5;
        mem_rdy = 1'b1;
        reset_a();
        #1;
        n_vec += 2;
        if (ia.req_valid !== 1'b1) begin n_err++; $display("FAIL basic_req_valid got %0b want 1", ia.req_valid); end
        if (ia.req_addr !== RST_A) begin n_err++; $display("FAIL basic_req_addr got %h want %h", ia.req_addr, RST_A); end
        wait_retire(10, seen, cyc);
        // cycle 1 is the FETCH_REQ cycle, so retire lands two edges later
        n_vec += 5;
        if (seen !== 1'b1) begin n_err++; $display("FAIL basic_timeout got %0b want 1", seen); end
        if (cyc !== 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", cyc); end
        if (a_rpc !== RST_A) begin n_err++; $display("FAIL basic_rpc got %h want %h", a_rpc, RST_A); end
        if (a_rrd !== 5'd1) begin n_err++; $display("FAIL basic_rd got %0d want 1", a_rrd); end
        if (a_rwd !== 32'd5) begin n_err++; $display("FAIL basic_wdata got %h want 5", a_rwd); end
    endtask

    task automatic test_stall();
        bit seen; int cyc; int bad;
        mem.delete();
        mem[RST_A] = ADDI_X1_5;
        mem_rdy = 1'b0;
        reset_a();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (ia.req_valid !== 1'b1 || ia.req_addr !== RST_A || a_rv !== 1'b0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        mem_rdy = 1'b1;
        wait_retire(10, seen, cyc);
        n_vec += 2;
        if (seen !== 1'b1 || cyc !== 2) begin n_err++; $display("FAIL stall_retire got seen=%0b cyc=%0d want 1/2", seen, cyc); end
        if (a_rpc !== RST_A) begin n_err++; $display("FAIL stall_rpc got %h want %h", a_rpc, RST_A); end
        @(negedge clk);
        n_vec++;
        if (a_rv !== 1'b0) begin n_err++; $display("FAIL stall_single got %0b want 0", a_rv); end
    endtask

    task automatic test_lui_addi();
        bit seen; int cyc;
        logic [31:0] exp_pc [3];
        logic [4:0]  exp_rd [3];
        logic [31:0] exp_wd [3];
        exp_pc = '{RST_A, RST_A + 32'd4, RST_A + 32'd8};
        exp_rd = '{5'd2, 5'd2, 5'd0};
        exp_wd = '{32'hFFFF_F000, 32'hFFFF_EFFF, 32'h0};
        mem.delete();
        mem[RST_A]        = LUI_X2;
        mem[RST_A + 32'd4] = ADDI_X2_M1;
        mem[RST_A + 32'd8] = ADDI_X0_7;
        reset_a();
        for (int i = 0; i < 3; i++) begin
            wait_retire(10, seen, cyc);
            n_vec += 3;
            if (!seen || a_rpc !== exp_pc[i]) begin n_err++; $display("FAIL lui_rpc%0d got %h want %h", i, a_rpc, exp_pc[i]); end
            if (a_rrd !== exp_rd[i]) begin n_err++; $display("FAIL lui_rd%0d got %0d want %0d", i, a_rrd, exp_rd[i]); end
            if (a_rwd !== exp_wd[i]) begin n_err++; $display("FAIL lui_wdata%0d got %h want %h", i, a_rwd, exp_wd[i]); end
        end
    endtask

    task automatic test_jal_auipc();
        bit seen; int cyc;
        mem.delete();
        mem[RST_A]         = AUIPC_X5_1;
        mem[RST_A + 32'd4] = JAL_X6_8;
        mem[RST_A + 32'd8] = ADDI_X7_1;
        reset_a();
        wait_retire(10, seen, cyc);
        n_vec++;
        if (!seen || a_rrd !== 5'd5 || a_rwd !== 32'h8000_1000) begin n_err++; $display("FAIL auipc got rd=%0d wd=%h want 5/80001000", a_rrd, a_rwd); end
        wait_retire(10, seen, cyc);
        n_vec++;
        if (!seen || a_rrd !== 5'd6 || a_rwd !== 32'h8000_0008) begin n_err++; $display("FAIL jal got rd=%0d wd=%h want 6/80000008", a_rrd, a_rwd); end
        wait_retire(10, seen, cyc);
        n_vec++;
        if (!seen || a_rpc !== 32'h8000_000C || a_rrd !== 5'd0) begin n_err++; $display("FAIL jal_target got pc=%h rd=%0d want 8000000c/0", a_rpc, a_rrd); end
        @(negedge clk);
        n_vec += 2;
        if (a_halt !== 1'b1) begin n_err++; $display("FAIL ebreak_halt got %0b want 1", a_halt); end
        if (ia.req_valid !== 1'b0) begin n_err++; $display("FAIL stop_req got %0b want 0", ia.req_valid); end
    endtask

    task automatic test_jalr();
        bit seen; int cyc;
        mem.delete();
        mem[RST_A]         = ADDI_X3_101;
        mem[RST_A + 32'd4] = JALR_X3;
        reset_a();
        wait_retire(10, seen, cyc);
        wait_retire(10, seen, cyc);
        n_vec += 3;
        if (!seen || a_rpc !== RST_A + 32'd4) begin n_err++; $display("FAIL jalr_rpc got %h want %h", a_rpc, RST_A + 32'd4); end
        if (a_rrd !== 5'd3) begin n_err++; $display("FAIL jalr_rd got %0d want 3", a_rrd); end
        if (a_rwd !== 32'h8000_0008) begin n_err++; $display("FAIL jalr_wdata got %h want 80000008", a_rwd); end
        @(negedge clk);
        n_vec += 2;
        if (ia.req_valid !== 1'b1 || ia.req_addr !== 32'h0000_0100) begin n_err++; $display("FAIL jalr_target got v=%0b a=%h want 1/00000100", ia.req_valid, ia.req_addr); end
        if (a_pc !== 32'h0000_0100) begin n_err++; $display("FAIL jalr_pc got %h want 00000100", a_pc); end
    endtask

    task automatic test_rv32e();
        int n_ret; int n_req; logic [31:0] lpc; logic [4:0] lrd; logic [31:0] lwd;
        mem.delete();
        mem[RST_B] = ADDI_X17_1;
        reset_b();
        n_ret = 0; n_req = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_rv) n_ret++;
            if (b_ill && ib.req_valid) n_req++;
        end
        n_vec += 4;
        if (b_ill !== 1'b1) begin n_err++; $display("FAIL rv32e_illegal got %0b want 1", b_ill); end
        if (n_ret !== 0) begin n_err++; $display("FAIL rv32e_noretire got %0d want 0", n_ret); end
        if (n_req !== 0) begin n_err++; $display("FAIL rv32e_noreq got %0d want 0", n_req); end
        if (b_pc !== RST_B || b_halt !== 1'b0) begin n_err++; $display("FAIL rv32e_pc got %h halt=%0b want %h/0", b_pc, b_halt, RST_B); end
        mem[RST_B] = ADDI_X1_5;
        reset_b();
        n_ret = 0; n_req = 0; lpc = '0; lrd = '1; lwd = '1;
        repeat (10) begin
            @(negedge clk);
            if (b_rv) begin n_ret++; lpc = b_rpc; lrd = b_rrd; lwd = b_rwd; end
            if (b_halt && ib.req_valid) n_req++;
        end
        n_vec += 4;
        if (n_ret !== 2) begin n_err++; $display("FAIL rv32e_retires got %0d want 2", n_ret); end
        if (lpc !== RST_B + 32'd4 || lrd !== 5'd0 || lwd !== 32'd0) begin n_err++; $display("FAIL rv32e_ebreak got %h/%0d/%h want %h/0/0", lpc, lrd, lwd, RST_B + 32'd4); end
        if (b_halt !== 1'b1 || b_ill !== 1'b0) begin n_err++; $display("FAIL rv32e_halt got h=%0b i=%0b want 1/0", b_halt, b_ill); end
        if (n_req !== 0) begin n_err++; $display("FAIL rv32e_haltreq got %0d want 0", n_req); end
    endtask

    task automatic test_reset_midfetch();
        bit seen; int cyc;
        mem.delete();
        mem[RST_A]         = ADDI_X3_101;
        mem[RST_A + 32'd4] = ADDI_X7_1;
        reset_a();
        wait_retire(10, seen, cyc);
        n_vec++;
        if (!seen || a_rwd !== 32'h101) begin n_err++; $display("FAIL mid_setup got %h want 00000101", a_rwd); end
        repeat (2) @(negedge clk);
        n_vec++;
        if (ia.rsp_ready !== 1'b1) begin n_err++; $display("FAIL mid_inwait got %0b want 1", ia.rsp_ready); end
        rst_a = 1'b1;
        @(negedge clk);
        n_vec += 3;
        if (ia.req_valid !== 1'b0 || ia.rsp_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_hs got %0b/%0b want 0/0", ia.req_valid, ia.rsp_ready); end
        if (a_pc !== RST_A || ia.req_addr !== RST_A) begin n_err++; $display("FAIL mid_rst_pc got %h want %h", a_pc, RST_A); end
        if (a_halt !== 1'b0 || a_ill !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got %0b/%0b want 0/0", a_halt, a_ill); end
        mem[RST_A] = ADDI_X4_X3;
        @(negedge clk);
        rst_a = 1'b0;
        wait_retire(10, seen, cyc);
        n_vec += 2;
        if (!seen || a_rpc !== RST_A || a_rrd !== 5'd4) begin n_err++; $display("FAIL mid_refetch got %h/%0d want %h/4", a_rpc, a_rrd, RST_A); end
        if (a_rwd !== 32'd0) begin n_err++; $display("FAIL mid_regclear got %h want 0", a_rwd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_lui_addi();
        test_jal_auipc();
        test_jalr();
        test_rv32e();
        test_reset_midfetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
